playback_sequencer: RTL

//  Ping-pong playback controller for the sample BRAM feeding the sigma-delta/PWM output path.

---
 rtl/playback_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/playback_sequencer.sv
// Ping-pong playback sequencer for the sample BRAM.
//
// The BRAM is split into two halves. One 16-bit sample is read per
// sample-rate tick. Each half is flagged done as it drains so the PS can
// refill it. If the half being played has not been refilled in time, the
// MUTE sample is emitted instead and the underrun counter increments.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | stopped; divider and read pointer held at 0
// WAIT_TICK  | divider running; on tick issue a read or emit MUTE
// RD_WAIT    | read issued; wait RD_LAT clocks, then capture the sample
module playback_sequencer #(
    parameter int                 ADDR_W = 11,
    parameter int                 DATA_W = 16,
    parameter int                 RD_LAT = 1,
    parameter int                 DIV_W  = 16,
    parameter logic [DATA_W-1:0]  MUTE   = '0
) (
    input  logic              axi4lite_ext_aclk,
    input  logic              axi4lite_ext_aresetn,
    input  logic              enable,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        fill_set,
    input  logic [1:0]        done_ack,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [31:0]       bram_addr,
    input  logic [31:0]       bram_dout,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_vld,
    output logic [1:0]        filled,
    output logic [1:0]        done,
    output logic              irq,
    output logic              cur_half,
    output logic [15:0]       underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_RD_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0]        RD_LAT_M1 = 2'(RD_LAT - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [15:0]       UCNT_MAX  = 16'hFFFF;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [1:0]          rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                vld_q, vld_d;
    logic [1:0]          filled_q, filled_d;
    logic [1:0]          done_q, done_d;
    logic [15:0]         ucnt_q, ucnt_d;

    logic                tick;
    logic                half;
    logic                rd_issue;
    logic                drain;

    assign tick = (div_q == cfg_div);
    assign half = ptr_q[ADDR_W-1];

    // Only the low DATA_W bits of the BRAM word carry the sample.
    if (DATA_W < 32) begin : g_dout_upper
        logic unused_dout_upper;
        assign unused_dout_upper = ^bram_dout[31:DATA_W];
    end

    // Sequencing: divider, read pointer, read latency count, sample and underrun update.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        ptr_d    = ptr_q;
        rd_cnt_d = rd_cnt_q;
        sample_d = sample_q;
        vld_d    = 1'b0;
        ucnt_d   = ucnt_q;
        rd_issue = 1'b0;
        drain    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                ptr_d = '0;
                if (enable) begin
                    state_d = ST_WAIT_TICK;
                end
            end

            ST_WAIT_TICK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    ptr_d   = '0;
                end else begin
                    div_d = tick ? '0 : div_q + DIV_ONE;
                    if (tick) begin
                        if (filled_q[half]) begin
                            rd_issue = 1'b1;
                            rd_cnt_d = RD_LAT_M1;
                            state_d  = ST_RD_WAIT;
                        end else begin
                            // Underrun: hold the pointer, emit MUTE on the next clock.
                            sample_d = MUTE;
                            vld_d    = 1'b1;
                            if (ucnt_q != UCNT_MAX) begin
                                ucnt_d = ucnt_q + 16'd1;
                            end
                        end
                    end
                end
            end

            ST_RD_WAIT: begin
                if (!enable) begin
                    // The read in flight is dropped; its data is never presented.
                    state_d = ST_IDLE;
                    div_d   = '0;
                    ptr_d   = '0;
                end else begin
                    // Ticks landing here are dropped; the divider keeps running.
                    div_d = tick ? '0 : div_q + DIV_ONE;
                    if (rd_cnt_q == 2'd0) begin
                        sample_d = bram_dout[DATA_W-1:0];
                        vld_d    = 1'b1;
                        ptr_d    = ptr_q + PTR_ONE;
                        drain    = &ptr_q[ADDR_W-2:0];
                        state_d  = ST_WAIT_TICK;
                    end else begin
                        rd_cnt_d = rd_cnt_q - 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                ptr_d   = '0;
            end
        endcase
    end

    // Half flags: a PS set beats a same-cycle drain clear, a drain set beats a same-cycle ack.
    always_comb begin
        filled_d = filled_q;
        done_d   = done_q & ~done_ack;
        if (drain) begin
            filled_d[half] = 1'b0;
            done_d[half]   = 1'b1;
        end
        filled_d = filled_d | fill_set;
    end

    // State and datapath registers; reset also cancels any read in flight.
    always_ff @(posedge axi4lite_ext_aclk or negedge axi4lite_ext_aresetn) begin
        if (!axi4lite_ext_aresetn) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            ptr_q    <= '0;
            rd_cnt_q <= '0;
            sample_q <= '0;
            vld_q    <= 1'b0;
            filled_q <= '0;
            done_q   <= '0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            ptr_q    <= ptr_d;
            rd_cnt_q <= rd_cnt_d;
            sample_q <= sample_d;
            vld_q    <= vld_d;
            filled_q <= filled_d;
            done_q   <= done_d;
            ucnt_q   <= ucnt_d;
        end
    end

    // The address comes straight from the pointer flop and only moves at capture,
    // so it is stable for the whole read.
    assign bram_en      = rd_issue;
    assign bram_we      = 4'b0000;
    assign bram_addr    = {{(32-ADDR_W-2){1'b0}}, ptr_q, 2'b00};
    assign sample_o     = sample_q;
    assign sample_vld   = vld_q;
    assign filled       = filled_q;
    assign done         = done_q;
    assign irq          = |done_q;
    assign cur_half     = half;
    assign underrun_cnt = ucnt_q;

endmodule
